// File: rtl/axi_common_pkg.sv
// Shared AXI definitions used across the bridge and master blocks.
package axi_common;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-lite channel bundle; clock and reset travel separately on module ports.
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

endinterface

// File: rtl/axi_lite_mem_master.sv
// Single-outstanding memory-port to AXI-lite master bridge; all AXI valid/ready outputs are flops.
// Optional macro AXI_LITE_MEM_MASTER_ERR_EN: report non-OKAY AXI responses on resp_err.
module axi_lite_mem_master
  import axi_common::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_ADDR_WIDTH = 16,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  axi_lite_channel.master           master,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [STRB_WIDTH-1:0]     req_we,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err
);

  localparam int AXI_AW   = $bits(master.aw_addr);
  localparam int AXI_DW   = $bits(master.w_data);
  localparam int BYTE_OFS = $clog2(STRB_WIDTH);

  if (AXI_DW != DATA_WIDTH) begin : g_bad_data_width
    $fatal(1, "axi_lite_mem_master: DATA_WIDTH differs from the AXI channel data width");
  end
  if (BYTE_OFS + MEM_ADDR_WIDTH > AXI_AW) begin : g_bad_addr_width
    $fatal(1, "axi_lite_mem_master: word address does not fit the AXI address width");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RESP
  } state_e;

  state_e                      state_q, state_d;
  logic                        aw_valid_q, aw_valid_d;
  logic                        w_valid_q, w_valid_d;
  logic                        ar_valid_q, ar_valid_d;
  logic                        b_ready_q, b_ready_d;
  logic                        r_ready_q, r_ready_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]       resp_rdata_q, resp_rdata_d;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]       strb_q, strb_d;
  logic [AXI_AW-1:0]           axi_addr;
  logic                        b_hs;
  logic                        r_hs;

  assign axi_addr = AXI_AW'(addr_q) << BYTE_OFS;
  assign b_hs     = b_ready_q && master.b_valid;
  assign r_hs     = r_ready_q && master.r_valid;

  always_comb begin
    state_d      = state_q;
    aw_valid_d   = aw_valid_q;
    w_valid_d    = w_valid_q;
    ar_valid_d   = ar_valid_q;
    b_ready_d    = b_ready_q;
    r_ready_d    = r_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (|req_we) begin
            wdata_d    = req_wdata;
            strb_d     = req_we;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            b_ready_d  = 1'b1;
            state_d    = ST_WR;
          end else begin
            ar_valid_d = 1'b1;
            r_ready_d  = 1'b1;
            state_d    = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (aw_valid_q && master.aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && master.w_ready)   w_valid_d  = 1'b0;
        // An early B from a misbehaving slave still ends the write; pending AW/W are abandoned.
        if (b_hs) begin
          aw_valid_d   = 1'b0;
          w_valid_d    = 1'b0;
          b_ready_d    = 1'b0;
          resp_rdata_d = '0;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RD: begin
        if (ar_valid_q && master.ar_ready) ar_valid_d = 1'b0;
        if (r_hs) begin
          ar_valid_d   = 1'b0;
          r_ready_d    = 1'b0;
          resp_rdata_d = master.r_data;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      b_ready_q    <= 1'b0;
      r_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
    end else begin
      state_q      <= state_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      ar_valid_q   <= ar_valid_d;
      b_ready_q    <= b_ready_d;
      r_ready_q    <= r_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
    end
  end

`ifdef AXI_LITE_MEM_MASTER_ERR_EN
  logic [1:0] resp_code_q, resp_code_d;

  always_comb begin
    resp_code_d = resp_code_q;
    if (state_q == ST_WR && b_hs)      resp_code_d = master.b_resp;
    else if (state_q == ST_RD && r_hs) resp_code_d = master.r_resp;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) resp_code_q <= RESP_OKAY;
    else       resp_code_q <= resp_code_d;
  end

  assign resp_err = (resp_code_q != RESP_OKAY);
`else
  assign resp_err = 1'b0;
`endif

  assign req_ready       = (state_q == ST_IDLE);
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign master.aw_valid = aw_valid_q;
  assign master.aw_addr  = axi_addr;
  assign master.w_valid  = w_valid_q;
  assign master.w_data   = wdata_q;
  assign master.w_strb   = strb_q;
  assign master.b_ready  = b_ready_q;
  assign master.ar_valid = ar_valid_q;
  assign master.ar_addr  = axi_addr;
  assign master.r_ready  = r_ready_q;

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Randomized scoreboard bench: memory-backed AXI-lite slave with per-transaction stalls.
module tb_axi_lite_mem_master;
  import axi_common::*;

`ifdef AXI_LITE_MEM_MASTER_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) axi ();

  logic        req_valid, req_ready;
  logic [7:0]  req_we;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  axi_lite_mem_master #(.DATA_WIDTH(64), .MEM_ADDR_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .master(axi),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [63:0] data; logic err; } exp_t;
  exp_t exp_q[$];
  logic [63:0] ref_mem [int];
  logic [63:0] slv_mem [int];

  int d_aw, d_w, d_b, d_ar, d_r;
  logic d_err;
  logic [31:0] exp_axi_addr;
  logic [7:0]  exp_strb;
  int rr_hold;
  int n_b = 0;
  int n_wr = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_word(int a);
    logic [15:0] w;
    w = 16'(a);
    return {w ^ 16'h1234, w, ~w, w ^ 16'h5AA5};
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] wd, logic [7:0] strb);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (strb[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  // ---------------- slave, client response side and protocol monitor ----------------
  logic hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_resp;
  logic aw_done, w_done, ar_done;
  int   c_aw, c_w, c_b, c_ar, c_r;
  logic [31:0] s_awaddr, s_araddr;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        p_awv, p_wv, p_arv, p_respv, p_err;
  logic [31:0] p_awaddr, p_araddr;
  logic [63:0] p_wdata, p_rdata;

  task automatic slave_idle();
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
    axi.b_valid = 1'b0; axi.b_resp = RESP_OKAY;
    axi.r_valid = 1'b0; axi.r_resp = RESP_OKAY; axi.r_data = '0;
    resp_ready = 1'b0;
    {hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_resp} = '0;
    {aw_done, w_done, ar_done} = '0;
    c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
    {p_awv, p_wv, p_arv, p_respv, p_err} = '0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_rdata = '0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
  endtask

  initial begin
    exp_t e;
    int   wa;
    slave_idle();
    forever begin
      @(negedge clk);
      if (!rstn) begin
        slave_idle();
        continue;
      end
      // commit handshakes that happened on the last rising edge
      if (hs_aw) begin
        aw_done = 1'b1;
        check("aw_valid_drop", 64'(axi.aw_valid), 64'd0);
      end
      if (hs_w) begin
        w_done = 1'b1;
        check("w_valid_drop", 64'(axi.w_valid), 64'd0);
      end
      if (hs_w && !aw_done) check("aw_valid_held", 64'(axi.aw_valid), 64'd1);
      if (hs_aw && !w_done) check("w_valid_held", 64'(axi.w_valid), 64'd1);
      if (hs_b) begin
        axi.b_valid = 1'b0;
        aw_done = 1'b0; w_done = 1'b0;
        c_aw = 0; c_w = 0; c_b = 0;
        n_b++;
        check("b_ready_drop", 64'(axi.b_ready), 64'd0);
      end
      if (hs_ar) begin
        ar_done = 1'b1;
        check("ar_valid_drop", 64'(axi.ar_valid), 64'd0);
      end
      if (hs_r) begin
        axi.r_valid = 1'b0;
        ar_done = 1'b0;
        c_ar = 0; c_r = 0;
        check("r_ready_drop", 64'(axi.r_ready), 64'd0);
      end
      // payload stability while a handshake is pending
      if (p_awv && !hs_aw) check("aw_stable", {31'd0, axi.aw_valid, axi.aw_addr}, {31'd0, 1'b1, p_awaddr});
      if (p_wv && !hs_w)   check("w_stable", axi.w_valid ? axi.w_data : ~p_wdata, p_wdata);
      if (p_arv && !hs_ar) check("ar_stable", {31'd0, axi.ar_valid, axi.ar_addr}, {31'd0, 1'b1, p_araddr});
      if (p_respv && !hs_resp) begin
        check("resp_valid_stable", 64'(resp_valid), 64'd1);
        check("resp_rdata_stable", resp_rdata, p_rdata);
        check("resp_err_stable", 64'(resp_err), 64'(p_err));
      end
      if (axi.aw_valid || axi.w_valid || axi.ar_valid || axi.b_ready || axi.r_ready || resp_valid)
        check("req_ready_busy", 64'(req_ready), 64'd0);

      // drive slave and client-side ready signals
      if (axi.aw_valid && !aw_done) begin
        if (c_aw < d_aw) begin c_aw++; axi.aw_ready = 1'b0; end
        else axi.aw_ready = 1'b1;
      end else axi.aw_ready = 1'b0;
      if (axi.w_valid && !w_done) begin
        if (c_w < d_w) begin c_w++; axi.w_ready = 1'b0; end
        else axi.w_ready = 1'b1;
      end else axi.w_ready = 1'b0;
      if (axi.ar_valid && !ar_done) begin
        if (c_ar < d_ar) begin c_ar++; axi.ar_ready = 1'b0; end
        else axi.ar_ready = 1'b1;
      end else axi.ar_ready = 1'b0;
      if (aw_done && w_done && !axi.b_valid) begin
        if (c_b < d_b) c_b++;
        else begin
          axi.b_valid = 1'b1;
          axi.b_resp  = d_err ? RESP_SLVERR : RESP_OKAY;
          wa = int'(s_awaddr >> 3);
          if (!d_err) slv_mem[wa] = merge(slv_mem.exists(wa) ? slv_mem[wa] : init_word(wa), s_wdata, s_wstrb);
        end
      end
      if (ar_done && !axi.r_valid) begin
        if (c_r < d_r) c_r++;
        else begin
          wa = int'(s_araddr >> 3);
          axi.r_valid = 1'b1;
          axi.r_resp  = d_err ? RESP_SLVERR : RESP_OKAY;
          axi.r_data  = slv_mem.exists(wa) ? slv_mem[wa] : init_word(wa);
        end
      end
      if (resp_valid && rr_hold > 0) begin
        resp_ready = 1'b0;
        rr_hold--;
      end else resp_ready = ($urandom_range(0, 3) != 0);

      // handshakes that will occur on the coming rising edge
      hs_aw = axi.aw_valid && axi.aw_ready;
      hs_w  = axi.w_valid && axi.w_ready;
      hs_b  = axi.b_valid && axi.b_ready;
      hs_ar = axi.ar_valid && axi.ar_ready;
      hs_r  = axi.r_valid && axi.r_ready;
      hs_resp = resp_valid && resp_ready;
      if (hs_aw) begin
        s_awaddr = axi.aw_addr;
        check("aw_addr", 64'(axi.aw_addr), 64'(exp_axi_addr));
      end
      if (hs_w) begin
        s_wdata = axi.w_data;
        s_wstrb = axi.w_strb;
        check("w_strb", 64'(axi.w_strb), 64'(exp_strb));
      end
      if (hs_ar) begin
        s_araddr = axi.ar_addr;
        check("ar_addr", 64'(axi.ar_addr), 64'(exp_axi_addr));
      end
      if (hs_resp) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got response %h with nothing outstanding", resp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e.data);
          check("resp_err", 64'(resp_err), 64'(e.err));
        end
      end
      p_awv = axi.aw_valid; p_awaddr = axi.aw_addr;
      p_wv  = axi.w_valid;  p_wdata  = axi.w_data;
      p_arv = axi.ar_valid; p_araddr = axi.ar_addr;
      p_respv = resp_valid; p_rdata = resp_rdata; p_err = resp_err;
    end
  end

  // ---------------- stimulus and reference model ----------------
  task automatic issue(logic [7:0] we, logic [15:0] addr, logic [63:0] wd,
                       int daw, int dw, int db, int dar, int dr, logic err);
    int   n;
    int   wa;
    exp_t e;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL req_accept_timeout: req_ready stayed 0 for %0d cycles", n);
        req_valid = 1'b0;
        return;
      end
    end
    d_aw = daw; d_w = dw; d_b = db; d_ar = dar; d_r = dr; d_err = err;
    exp_axi_addr = {13'd0, addr, 3'd0};
    exp_strb = we;
    wa = int'(addr);
    e.err = ERR_BUILD && err;
    if (we != 8'd0) begin
      n_wr++;
      e.data = 64'd0;
      if (!err) ref_mem[wa] = merge(ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa), wd, we);
    end else e.data = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = $urandom_range(0, 255);
    req_addr = $urandom_range(0, 65535);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 || !req_ready) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL idle_timeout: %0d responses still outstanding", exp_q.size());
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    req_valid = 1'b0; req_we = '0; req_addr = '0; req_wdata = '0;
    rr_hold = 0; d_aw = 0; d_w = 0; d_b = 0; d_ar = 0; d_r = 0; d_err = 1'b0;
    exp_axi_addr = '0; exp_strb = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_axi_ctrl", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, resp_valid}), 64'd0);
    check("reset_resp", {resp_rdata[62:0], resp_err}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // zero-wait write latency
    issue(8'hFF, 16'h0010, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0, 0, 1'b0);
    check("lat_awv_wv", 64'({axi.aw_valid, axi.w_valid}), 64'd3);
    check("lat_aw_addr", 64'(axi.aw_addr), 64'h80);
    check("lat_w_strb", 64'(axi.w_strb), 64'hFF);
    @(negedge clk);
    check("lat_resp_c2", 64'(resp_valid), 64'd0);
    @(negedge clk);
    check("lat_resp_c3", 64'(resp_valid), 64'd1);
    wait_idle();

    // stalled read of a known value
    issue(8'hFF, 16'h0020, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0, 1'b0);
    issue(8'h00, 16'h0020, 64'd0, 0, 0, 0, 3, 2, 1'b0);
    wait_idle();

    // W accepted before AW
    issue(8'h0F, 16'h0020, 64'hFFFF_EEEE_1111_2222, 4, 2, 0, 0, 0, 1'b0);
    wait_idle();
    check("b_count_w_first", 64'(n_b), 64'(n_wr));

    // client stalls the response, next request offered immediately
    rr_hold = 5;
    issue(8'h00, 16'h0020, 64'd0, 1, 0, 1, 0, 0, 1'b0);
    issue(8'h3C, 16'h0005, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0, 0, 0, 0, 1'b0);
    wait_idle();

    // error responses
    issue(8'h00, 16'h0005, 64'd0, 0, 0, 0, 1, 1, 1'b1);
    issue(8'hF0, 16'h0006, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 0, 1'b1);
    wait_idle();

    // reset asserted while the read address is stalled
    issue(8'h00, 16'h0003, 64'd0, 0, 0, 0, 20, 0, 1'b0);
    check("rst_pre_arv", 64'(axi.ar_valid), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_ar_rr", 64'({axi.ar_valid, axi.r_ready}), 64'd0);
    check("rst_async_req_ready", 64'(req_ready), 64'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(negedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    check("rst_release_req_ready", 64'(req_ready), 64'd1);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [7:0] we;
      we = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      issue(we, 16'($urandom_range(0, 15)), {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 4) == 0) rr_hold = $urandom_range(1, 4);
    end
    wait_idle();
    check("b_count_total", 64'(n_b), 64'(n_wr));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_master.md
Name: axi_lite_mem_master

Overview:
Converts a simple single-port memory request/response interface into AXI-lite master transactions. It serves as the initiator counterpart of the AXI-lite slave bridges, letting BRAM-style client logic (CPU fetch stubs, DMA helpers, config engines) reach any AXI-lite slave. It allows one outstanding transaction at a time. All AXI-facing valid/ready outputs are registered, so there are no combinational paths from AXI inputs to AXI outputs.

Parameters:
DATA_WIDTH, 64, data width in bits; must equal master.DATA_WIDTH; STRB_WIDTH = DATA_WIDTH/8.
MEM_ADDR_WIDTH, 16, word-address width of the client port; $clog2(STRB_WIDTH)+MEM_ADDR_WIDTH must be <= master.ADDR_WIDTH, else $fatal at elaboration.

Ports:
clk  input  1  clock.
rstn  input  1  reset, asynchronous, active-low.
master  axi_lite_channel.master  -  AXI-lite initiator port. clk/rstn are taken from the ports, not from the interface.
req_valid  input  1  client request valid.
req_ready  output  1  request accepted when req_valid && req_ready.
req_we  input  STRB_WIDTH  byte write enables; nonzero = write, zero = read.
req_addr  input  MEM_ADDR_WIDTH  word address.
req_wdata  input  DATA_WIDTH  write data.
resp_valid  output  1  response valid; held until resp_ready.
resp_ready  input  1  client accepts response.
resp_rdata  output  DATA_WIDTH  read data; zero for writes.
resp_err  output  1  AXI response was not OKAY (see Optional Feature).

Behaviour:
- States: IDLE, WR (AW/W/B phase), RD (AR/R phase), RESP.
- Reset: state=IDLE; aw_valid, w_valid, ar_valid, b_ready, r_ready, resp_valid = 0; resp_rdata = 0; resp_err = 0. req_ready = (state==IDLE), so it is 1 after reset.
- Address mapping: AXI addr = {zero-pad, req_addr, $clog2(STRB_WIDTH) zero bits}. Upper bits are zero.
- IDLE accepting a request with req_we != 0:
  - Register addr, wdata and strb.
  - Next cycle: aw_valid=1, w_valid=1, b_ready=1; state=WR.
- IDLE accepting a request with req_we == 0:
  - Register addr.
  - Next cycle: ar_valid=1, r_ready=1; state=RD.
- WR:
  - aw_valid and w_valid drop independently on their own handshakes, in any order, including the same cycle.
  - The AW and W payloads stay stable until each handshake.
  - B is accepted whenever it arrives. A B before both AW and W have completed is a slave protocol violation; ignore the ordering and accept it anyway.
  - On B handshake: b_ready=0, latch b_resp, resp_rdata=0, state=RESP, resp_valid=1 next cycle.
- RD:
  - ar_valid drops on AR handshake. r_ready stays 1 until the R handshake.
  - On R handshake: latch r_data and r_resp, r_ready=0, state=RESP, resp_valid=1.
- RESP:
  - resp_valid, resp_rdata and resp_err hold stable until resp_ready.
  - On handshake: resp_valid=0, state=IDLE. A new request can be accepted the following cycle, not the same cycle.
- Minimum latency with zero-wait slave:
  - request accepted in cycle 0; AW/W valid in cycle 1 (handshake); B arrives in cycle 2; resp_valid in cycle 3.
  - Reads are the same: AR in cycle 1, R in cycle 2, resp in cycle 3.
  - Back-to-back throughput is 1 transaction per 4 cycles.
- req_ready=0 in WR, RD and RESP. Requests offered there are held by the client, not dropped.
- Stalls: an arbitrary slave stall on any channel has no timeout; the block waits indefinitely.
- Reset mid-transaction: everything returns to reset values immediately. Any outstanding AXI transaction is abandoned; the slave must be reset in the same domain.

Optional Feature:
Macro AXI_LITE_MEM_MASTER_ERR_EN.
- Defined: resp_err = 1 when the latched b_resp/r_resp != axi_common::RESP_OKAY. Read data is still passed through.
- Undefined: resp_err is tied to 0, and b_resp/r_resp are not stored.
- Port list is identical in both builds.

Decomposition:
- RESP_* codes come from the existing axi_common package.
- The state enum is local to the module, since it is not shared.
- No sub-module. regslice is not needed because all AXI outputs are registered and each ready/valid depends only on state.

Test Plan:
- Write, zero-wait slave: req_we=8'hFF, req_addr=16'h0010, req_wdata=64'hDEADBEEF_CAFEF00D -> aw_addr=32'h80, w_strb=8'hFF in cycle 1; resp_valid in cycle 3; resp_err=0; resp_rdata=0.
- Read, slave stalls AR 3 cycles and R 2 cycles with r_data=64'h0123_4567_89AB_CDEF -> ar_addr held stable; resp_rdata=64'h0123_4567_89AB_CDEF; req_ready low throughout.
- Slave takes W 2 cycles before AW (aw_ready delayed 4) -> w_valid drops after its handshake while aw_valid stays high; exactly one B is consumed; one response is returned.
- Client holds resp_ready=0 for 5 cycles -> resp fields stable; req_ready=0; a new req_valid is not accepted until the cycle after the response handshake.
- With AXI_LITE_MEM_MASTER_ERR_EN, slave returns SLVERR on a read -> resp_err=1, data passed through. Without the macro, same stimulus -> resp_err=0.
- Assert rstn low during the RD state with ar_valid=1 -> ar_valid and r_ready go to 0 asynchronously; after release, state is IDLE and req_ready=1.
